// File: rtl/mips_multicycle_ctrl.sv
// Purpose: Moore control FSM for the multicycle MIPS datapath. Decodes the
//          opcode and walks each instruction through fetch, decode, execute,
//          memory and writeback, driving every datapath enable and mux select.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset (forces FETCH, clears illegal)
//   op       - instr[31:26] from the instruction register
//   zero     - ALU zero flag (only used for beq)
//   aluop    - 00 add, 01 sub, 10 use funct
//   alusrca  - 0 PC, 1 regA
//   alusrcb  - 00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc    - 00 ALU result, 01 ALUOut, 10 jump target
//   iord     - memory address select: 0 PC, 1 ALUOut
//   irwrite  - instruction register load
//   memwrite - memory write strobe
//   regwrite - register file write
//   regdst   - 0 rt, 1 rd
//   memtoreg - 0 ALUOut, 1 data register
//   pcen     - PC load enable (pcwrite | branch & zero)
//   illegal  - sticky unsupported-opcode flag
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic       illegal
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  // Encodings 4'hC-4'hF are unused and fall through to the default arm.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEMADR   = 4'h2,
    S_MEMRD    = 4'h3,
    S_MEMWB    = 4'h4,
    S_MEMWR    = 4'h5,
    S_EXECUTE  = 4'h6,
    S_ALUWB    = 4'h7,
    S_BRANCH   = 4'h8,
    S_ADDIEXEC = 4'h9,
    S_ADDIWB   = 4'hA,
    S_JUMP     = 4'hB
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   pcwrite, branch;

  // State and sticky illegal flag; reset acts without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore output decode; pcen is the only zero-dependent output.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    aluop     = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_RTYPE)        state_d = S_EXECUTE;
        else if (op == OP_BEQ)          state_d = S_BRANCH;
        else if (op == OP_ADDI)         state_d = S_ADDIEXEC;
        else if (op == OP_J)            state_d = S_JUMP;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    pcen = pcwrite | (branch & zero);
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose: self-checking bench for mips_multicycle_ctrl. A reference model
//          expands each opcode into its list of named steps and gives the
//          control word each step must show; directed and random instruction
//          streams are compared cycle by cycle.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic [1:0] aluop;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, pcen, illegal;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       pcen;
  } ctl_t;

  int vectors    = 0;
  int miscompares = 0;
  logic ill_model = 1'b0;

  mips_multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .aluop    (aluop),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .iord     (iord),
    .irwrite  (irwrite),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .pcen     (pcen),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  // Step list each instruction walks through, starting at FETCH.
  function automatic void steps_for(input logic [5:0] o, output string s[$]);
    s = {"FETCH", "DECODE"};
    case (o)
      6'b100011: s = {s, "MEMADR", "MEMRD", "MEMWB"};
      6'b101011: s = {s, "MEMADR", "MEMWR"};
      6'b000000: s = {s, "EXECUTE", "ALUWB"};
      6'b001000: s = {s, "ADDIEXEC", "ADDIWB"};
      6'b000100: s = {s, "BRANCH"};
      6'b000010: s = {s, "JUMP"};
      default:   ;
    endcase
  endfunction

  // Control word required in a named step; unlisted signals are 0.
  function automatic ctl_t exp_ctl(input string s, input logic z);
    ctl_t c;
    c = '0;
    case (s)
      "FETCH":    begin c.irwrite = 1; c.alusrcb = 2'b01; c.pcen = 1; end
      "DECODE":   begin c.alusrcb = 2'b11; end
      "MEMADR":   begin c.alusrca = 1; c.alusrcb = 2'b10; end
      "MEMRD":    begin c.iord = 1; end
      "MEMWB":    begin c.regwrite = 1; c.memtoreg = 1; end
      "MEMWR":    begin c.iord = 1; c.memwrite = 1; end
      "EXECUTE":  begin c.alusrca = 1; c.aluop = 2'b10; end
      "ALUWB":    begin c.regwrite = 1; c.regdst = 1; end
      "BRANCH":   begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = z; end
      "ADDIEXEC": begin c.alusrca = 1; c.alusrcb = 2'b10; end
      "ADDIWB":   begin c.regwrite = 1; end
      "JUMP":     begin c.pcsrc = 2'b10; c.pcen = 1; end
      default:    ;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input string step);
    ctl_t obs, exp;
    obs = '{aluop, alusrca, alusrcb, pcsrc, iord, irwrite, memwrite,
            regwrite, regdst, memtoreg, pcen};
    exp = exp_ctl(step, zero);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s ctl observed=%h expected=%h", tag, step, obs, exp);
    end
    vectors++;
    assert (illegal === ill_model) else begin
      miscompares++;
      $error("FAIL %s/%s illegal observed=%b expected=%b", tag, step, illegal, ill_model);
    end
  endtask

  // zmode: 0 random zero, 1 force zero=1, 2 force zero=0.
  // stop_at: return right after checking that step index (-1 runs to the end).
  task automatic run_instr(input string tag, input logic [5:0] iop,
                           input int zmode, input int stop_at);
    string s[$];
    steps_for(iop, s);
    for (int k = 0; k < s.size(); k++) begin
      @(negedge clk);
      // op only matters where it is sampled; scramble it everywhere else
      op = (s[k] == "DECODE" || s[k] == "MEMADR") ? iop : 6'($urandom);
      zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom);
      #1;
      check(tag, s[k]);
      if (s[k] == "DECODE" && !is_legal(iop)) ill_model = 1'b1;
      if (k == stop_at) return;
    end
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] r;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    reset = 1'b0;
    op    = 6'b000000;
    zero  = 1'b1;

    // Held in reset: FETCH outputs, illegal clear.
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold", "FETCH");
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr("lw",       6'b100011, 0, -1);
    run_instr("rtype",    6'b000000, 0, -1);
    run_instr("beq_z1",   6'b000100, 1, -1);
    run_instr("beq_z0",   6'b000100, 2, -1);
    run_instr("sw",       6'b101011, 0, -1);
    run_instr("j",        6'b000010, 0, -1);
    run_instr("illegal",  6'b111111, 0, -1);
    run_instr("addi_ill", 6'b001000, 0, -1);

    // Reset clears the sticky flag.
    @(negedge clk);
    #2 reset = 1'b0;
    ill_model = 1'b0;
    #1;
    check("rst_clr", "FETCH");
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset asserted between edges while in MEMWR.
    run_instr("sw_abort", 6'b101011, 0, 3);
    #2 reset = 1'b0;
    #1;
    check("rst_memwr", "FETCH");
    @(posedge clk);
    #1;
    check("rst_memwr_held", "FETCH");
    reset = 1'b1;

    // Random instruction stream, roughly one in seven unsupported.
    for (int n = 0; n < 300; n++) begin
      int idx;
      idx = int'($urandom_range(0, 6));
      if (idx < 6) r = legal_ops[idx];
      else begin
        r = 6'($urandom);
        while (is_legal(r)) r = 6'($urandom);
      end
      run_instr("rand", r, 0, -1);
      if (n == 150) begin
        @(negedge clk);
        #2 reset = 1'b0;
        ill_model = 1'b0;
        #1;
        check("rand_rst", "FETCH");
        @(posedge clk);
        #1 reset = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
